// File: rtl/lif_accum.sv
// Leaky integrate-and-fire membrane accumulator for a single neuron.
// v feeds an external registered comparator whose result returns as fire.
module lif_accum #(
    parameter int DATA_W   = 16,
    parameter int IN_W     = 12,
    parameter int LEAK_SH  = 4,
    parameter int REFR_CYC = 8,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [IN_W-1:0]   in_data,
    output logic                     in_ready,
    input  logic                     fire,
    output logic        [DATA_W-1:0] v,
    output logic                     spike,
    output logic                     refr,
    output logic        [CNT_W-1:0]  spike_cnt
);

    localparam int SUM_W     = DATA_W + 2;
    localparam int RC_W      = (REFR_CYC > 1) ? $clog2(REFR_CYC) : 1;
    localparam int REFR_LAST = (REFR_CYC > 0) ? REFR_CYC - 1 : 0;

    typedef enum logic [1:0] {
        ST_INTEG,
        ST_FIRED,
        ST_REFR
    } state_t;

    state_t           state;
    logic [RC_W-1:0]  refr_cnt;

    logic signed [SUM_W-1:0] v_ext;
    logic signed [SUM_W-1:0] leak_ext;
    logic signed [SUM_W-1:0] acc_ext;
    logic signed [SUM_W-1:0] sum;
    logic        [DATA_W-1:0] v_sat;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        v_ext    = $signed({2'b00, v});
        leak_ext = $signed({2'b00, v >> LEAK_SH});
        acc_ext  = '0;
        if (in_valid)
            acc_ext = {{(SUM_W - IN_W){in_data[IN_W-1]}}, in_data};
        sum = v_ext - leak_ext + acc_ext;

        // Sign bit means underflow; bit DATA_W set on a positive sum means overflow.
        v_sat = sum[DATA_W-1:0];
        if (sum[SUM_W-1])
            v_sat = '0;
        else if (sum[DATA_W])
            v_sat = '1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INTEG;
            v         <= '0;
            spike     <= 1'b0;
            refr      <= 1'b0;
            in_ready  <= 1'b1;
            spike_cnt <= '0;
            refr_cnt  <= '0;
        end else begin
            case (state)
                ST_INTEG: begin
                    if (fire) begin
                        v        <= '0;
                        state    <= ST_FIRED;
                        spike    <= 1'b1;
                        refr     <= 1'b1;
                        in_ready <= 1'b0;
                    end else begin
                        v <= v_sat;
                    end
                end

                // fire here is stale: it still reflects v from before the clear.
                ST_FIRED: begin
                    v         <= '0;
                    spike     <= 1'b0;
                    spike_cnt <= spike_cnt + 1'b1;
                    refr_cnt  <= '0;
                    if (REFR_CYC > 0) begin
                        state <= ST_REFR;
                    end else begin
                        state    <= ST_INTEG;
                        refr     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end

                ST_REFR: begin
                    v <= '0;
                    if (refr_cnt == RC_W'(REFR_LAST)) begin
                        state    <= ST_INTEG;
                        refr     <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        refr_cnt <= refr_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= ST_INTEG;
                    v        <= '0;
                    spike    <= 1'b0;
                    refr     <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
